// File: rtl/ct_spsram_pkg.sv
// Shared types and constants for the parametrised single-port SRAM wrapper.
// Holds the init FSM encoding, read-latency helper and LSU array defaults.
package ct_spsram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } spsram_state_e;

  localparam int LSU_ADDR_WIDTH = 8;
  localparam int LSU_DEPTH      = 256;
  localparam int LSU_DATA_WIDTH = 54;

  function automatic int rd_latency(input int out_reg);
    return 1 + out_reg;
  endfunction

endpackage

// File: rtl/ct_spsram_param_init_if.sv
// Access bus between LSU array control (master) and the SRAM wrapper (slave).
// Carries the macro-style active-low controls, read return and init handshake.
interface ct_spsram_param_init_if
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) ();

  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  Q_VLD;
  logic                  INIT_REQ;
  logic                  INIT_BUSY;

  modport master (
    output CEN, GWEN, WEN, A, D, INIT_REQ,
    input  Q, Q_VLD, INIT_BUSY
  );

  modport slave (
    input  CEN, GWEN, WEN, A, D, INIT_REQ,
    output Q, Q_VLD, INIT_BUSY
  );

endinterface

// File: rtl/ct_f_spsram_param.sv
// Behavioural single-port storage array: one-cycle read, per-bit masked write.
// Q only changes on a read; swapped for the foundry macro in ASIC builds.
module ct_f_spsram_param
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DEPTH      = LSU_DEPTH,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem_q[A] <= (mem_q[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem_q[A];
      end
    end
  end

endmodule

// File: rtl/ct_spsram_param_init.sv
// SRAM wrapper with hardware clear engine, address range check and optional Q stage.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); external access is ignored while INIT_BUSY.
module ct_spsram_param_init
  import ct_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = LSU_ADDR_WIDTH,
  parameter int                    DEPTH       = LSU_DEPTH,
  parameter int                    DATA_WIDTH  = LSU_DATA_WIDTH,
  parameter int                    OUT_REG     = 0,
  parameter int                    INIT_ON_RST = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  ct_spsram_param_init_if.slave  bus
);

  localparam int                    RD_LAT    = rd_latency(OUT_REG);
  localparam spsram_state_e         RST_STATE = (INIT_ON_RST != 0) ? INIT : IDLE;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  spsram_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  oor_q, oor_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic                  in_range;
  logic                  m_cen, m_gwen;
  logic [DATA_WIDTH-1:0] m_wen, m_d, m_q;
  logic [ADDR_WIDTH-1:0] m_a;
  logic [DATA_WIDTH-1:0] s1_dat;

  // Extra bit so DEPTH == 2**ADDR_WIDTH does not wrap the bound to zero.
  assign in_range = ({1'b0, bus.A} < (ADDR_WIDTH + 1)'(DEPTH));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_vld_d = 1'b0;
    oor_d    = 1'b0;
    m_cen    = 1'b1;
    m_gwen   = 1'b1;
    m_wen    = '1;
    m_a      = bus.A;
    m_d      = bus.D;
    case (state_q)
      IDLE: begin
        if (bus.INIT_REQ) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (!bus.CEN) begin
          if (in_range) begin
            m_cen  = 1'b0;
            m_gwen = bus.GWEN;
            m_wen  = bus.WEN;
          end
          if (bus.GWEN) begin
            rd_vld_d = 1'b1;
            oor_d    = !in_range;
          end
        end
      end
      INIT: begin
        m_cen  = 1'b0;
        m_gwen = 1'b0;
        m_wen  = '0;
        m_a    = cnt_q;
        m_d    = INIT_VALUE;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  ct_f_spsram_param #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .CLK  (CLK),
    .CEN  (m_cen),
    .GWEN (m_gwen),
    .WEN  (m_wen),
    .A    (m_a),
    .D    (m_d),
    .Q    (m_q)
  );

  assign s1_dat = oor_q ? '0 : m_q;
  assign hold_d = rd_vld_q ? s1_dat : hold_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      oor_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      oor_q    <= oor_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.INIT_BUSY = (state_q == INIT);

  // hold_q doubles as the Q pipeline register when the extra stage is enabled.
  if (RD_LAT == 2) begin : g_out_reg
    logic vld2_q;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        vld2_q <= 1'b0;
      end else begin
        vld2_q <= rd_vld_q;
      end
    end
    assign bus.Q     = hold_q;
    assign bus.Q_VLD = vld2_q;
  end else begin : g_no_reg
    assign bus.Q     = hold_d;
    assign bus.Q_VLD = rd_vld_q;
  end

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Bench for ct_spsram_param_init: three configurations driven in parallel and
// checked every cycle against a behavioural array/latency model.
module tb_ct_spsram_param_init;

  localparam int AW = 8;
  localparam int DW = 54;
  localparam int NI = 3;
  localparam int DEP [NI] = '{256, 256, 200};
  localparam int LAT [NI] = '{1, 2, 1};
  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] IV1  = 54'h2_AAAA_5555_1234;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          cen, gwen, init_req;
  logic [DW-1:0] wen, d;
  logic [AW-1:0] a;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  initial forever #5 CLK = ~CLK;

  ct_spsram_param_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  ct_spsram_param_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  ct_spsram_param_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

  assign if0.CEN = cen;  assign if0.GWEN = gwen; assign if0.WEN = wen;
  assign if0.A = a;      assign if0.D = d;       assign if0.INIT_REQ = init_req;
  assign if1.CEN = cen;  assign if1.GWEN = gwen; assign if1.WEN = wen;
  assign if1.A = a;      assign if1.D = d;       assign if1.INIT_REQ = init_req;
  assign if2.CEN = cen;  assign if2.GWEN = gwen; assign if2.WEN = wen;
  assign if2.A = a;      assign if2.D = d;       assign if2.INIT_REQ = init_req;

  ct_spsram_param_init #(.ADDR_WIDTH(AW), .DEPTH(256), .DATA_WIDTH(DW), .OUT_REG(0),
                         .INIT_ON_RST(1), .INIT_VALUE('0))
    u0 (.CLK(CLK), .RST(RST), .bus(if0));
  ct_spsram_param_init #(.ADDR_WIDTH(AW), .DEPTH(256), .DATA_WIDTH(DW), .OUT_REG(1),
                         .INIT_ON_RST(1), .INIT_VALUE(IV1))
    u1 (.CLK(CLK), .RST(RST), .bus(if1));
  ct_spsram_param_init #(.ADDR_WIDTH(AW), .DEPTH(200), .DATA_WIDTH(DW), .OUT_REG(0),
                         .INIT_ON_RST(1), .INIT_VALUE('0))
    u2 (.CLK(CLK), .RST(RST), .bus(if2));

  logic [DW-1:0] q_a [NI];
  logic          vld_a [NI];
  logic          busy_a [NI];
  assign q_a[0] = if0.Q; assign vld_a[0] = if0.Q_VLD; assign busy_a[0] = if0.INIT_BUSY;
  assign q_a[1] = if1.Q; assign vld_a[1] = if1.Q_VLD; assign busy_a[1] = if1.INIT_BUSY;
  assign q_a[2] = if2.Q; assign vld_a[2] = if2.Q_VLD; assign busy_a[2] = if2.INIT_BUSY;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mem_m [NI][256];
  logic          busy_m [NI];
  int            left_m [NI];
  logic [DW-1:0] q_m [NI];
  logic          vld_m [NI];
  logic          slot_v [NI][4];
  logic [DW-1:0] slot_d [NI][4];
  int            cyc = 0;

  function automatic logic [DW-1:0] init_val(input int k);
    return (k == 1) ? IV1 : '0;
  endfunction

  task automatic start_init(input int k);
    busy_m[k] = 1'b1;
    left_m[k] = DEP[k];
    for (int i = 0; i < 256; i++) mem_m[k][i] = init_val(k);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      start_init(k);
      q_m[k]   = '0;
      vld_m[k] = 1'b0;
      for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input int c);
    int due;
    if (busy_m[k]) begin
      left_m[k]--;
      if (left_m[k] == 0) busy_m[k] = 1'b0;
    end else if (init_req) begin
      start_init(k);
    end else if (!cen) begin
      if (!gwen) begin
        if (int'(a) < DEP[k]) mem_m[k][a] = (mem_m[k][a] & wen) | (d & ~wen);
      end else begin
        due = (c + LAT[k] - 1) % 4;
        slot_v[k][due] = 1'b1;
        slot_d[k][due] = (int'(a) < DEP[k]) ? mem_m[k][a] : '0;
      end
    end
    vld_m[k] = slot_v[k][c % 4];
    if (vld_m[k]) begin
      q_m[k] = slot_d[k][c % 4];
      slot_v[k][c % 4] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) model_reset();
      else begin
        cyc++;
        for (int k = 0; k < NI; k++) model_step(k, cyc);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("u%0d_busy@%0d", k, cyc), 64'(busy_a[k]), 64'(busy_m[k]));
        chk($sformatf("u%0d_qvld@%0d", k, cyc), 64'(vld_a[k]), 64'(vld_m[k]));
        chk($sformatf("u%0d_q@%0d", k, cyc), 64'(q_a[k]), 64'(q_m[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    cen = 1'b1; gwen = 1'b1; init_req = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic op(input logic c_, input logic g_, input logic [DW-1:0] w_,
                    input logic [AW-1:0] a_, input logic [DW-1:0] d_, input logic r_);
    cen = c_; gwen = g_; wen = w_; a = a_; d = d_; init_req = r_;
    @(posedge CLK); #1;
    cen = 1'b1; init_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a_, input logic [DW-1:0] d_, input logic [DW-1:0] w_);
    op(1'b0, 1'b0, w_, a_, d_, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a_);
    op(1'b0, 1'b1, ONES, a_, '0, 1'b0);
  endtask

  // Counts cycles with INIT_BUSY high, poking a write to A=7 and a stray INIT_REQ meanwhile.
  task automatic count_busy(input string nm);
    int  n [NI];
    bit  any;
    for (int k = 0; k < NI; k++) n[k] = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 0) begin cen = 1'b0; gwen = 1'b0; wen = '0; a = 8'd7; d = ONES; end
      if (i == 50) init_req = 1'b1;
      @(negedge CLK);
      any = 1'b0;
      for (int k = 0; k < NI; k++) if (busy_a[k]) begin n[k]++; any = 1'b1; end
      if (!any) break;
      @(posedge CLK); #1;
      cen = 1'b1; init_req = 1'b0;
    end
    cen = 1'b1; init_req = 1'b0;
    for (int k = 0; k < NI; k++) chk($sformatf("%s_cycles_u%0d", nm, k), 64'(n[k]), 64'(DEP[k]));
  endtask

  logic [DW-1:0] exp5, v1, v2, v3, v10, rw, rd_d;
  logic [AW-1:0] ra;
  int            good;

  initial begin
    cen = 1'b1; gwen = 1'b1; wen = ONES; a = '0; d = '0; init_req = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_busy_u%0d", k), 64'(busy_a[k]), 64'd1);
      chk($sformatf("rst_qvld_u%0d", k), 64'(vld_a[k]), 64'd0);
      chk($sformatf("rst_q_u%0d", k), 64'(q_a[k]), 64'd0);
    end
    cmp_en = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    count_busy("boot");

    good = 0;
    for (int i = 0; i < 256; i++) begin
      rd(AW'(i));
      @(negedge CLK);
      if (vld_a[0] && q_a[0] == '0) good++;
    end
    chk("sweep_zero_reads_u0", 64'(good), 64'd256);

    idle(1);
    wr(8'h3C, ONES, '0);
    rd(8'h3C);
    @(negedge CLK);
    chk("raw_3c_q", 64'(q_a[0]), 64'(ONES));
    chk("raw_3c_vld", 64'(vld_a[0]), 64'd1);
    idle(1);
    @(negedge CLK);
    chk("raw_3c_vld_pulse", 64'(vld_a[0]), 64'd0);
    chk("raw_3c_q_hold", 64'(q_a[0]), 64'(ONES));

    exp5 = {46'h3FFF_FFFF_FFFF, 8'h00};
    wr(8'd5, ONES, '0);
    wr(8'd5, '0, ~54'hFF);
    rd(8'd5);
    @(negedge CLK);
    chk("mask_a5", 64'(q_a[0]), 64'(exp5));

    v1 = 54'h11_1111_1111_1111; v2 = 54'h22_2222_2222_2222; v3 = 54'h33_3333_3333_3333;
    wr(8'd1, v1, '0); wr(8'd2, v2, '0); wr(8'd3, v3, '0);
    idle(2);
    rd(8'd1); @(negedge CLK); chk("oreg_c1_vld", 64'(vld_a[1]), 64'd0);
    rd(8'd2); @(negedge CLK); chk("oreg_c2_q", 64'(q_a[1]), 64'(v1));
    rd(8'd3); @(negedge CLK); chk("oreg_c3_q", 64'(q_a[1]), 64'(v2));
    idle(1);  @(negedge CLK); chk("oreg_c4_q", 64'(q_a[1]), 64'(v3));
    chk("oreg_c4_vld", 64'(vld_a[1]), 64'd1);
    idle(1);  @(negedge CLK); chk("oreg_c5_vld", 64'(vld_a[1]), 64'd0);

    idle(2);
    op(1'b0, 1'b0, '0, 8'd9, ONES, 1'b1);
    idle(100);
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    count_busy("rst_mid");
    rd(8'd7);
    @(negedge CLK);
    chk("lost_wr_a7_u0", 64'(q_a[0]), 64'd0);
    idle(1);
    @(negedge CLK);
    chk("lost_wr_a7_u1", 64'(q_a[1]), 64'(IV1));

    v10 = 54'h0A_5A5A_C3C3_0F0F;
    wr(8'd10, v10, '0);
    wr(8'd210, ONES, '0);
    rd(8'd210);
    @(negedge CLK);
    chk("oor_q_u2", 64'(q_a[2]), 64'd0);
    chk("oor_vld_u2", 64'(vld_a[2]), 64'd1);
    chk("inrange_210_u0", 64'(q_a[0]), 64'(ONES));
    rd(8'd10);
    @(negedge CLK);
    chk("alias_a10_u2", 64'(q_a[2]), 64'(v10));

    for (int i = 0; i < 1500; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(195, 215)) : AW'($urandom_range(0, 15));
      rw = ($urandom_range(0, 1) == 0) ? '0 : DW'({$urandom(), $urandom()});
      rd_d = DW'({$urandom(), $urandom()});
      op($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), rw, ra, rd_d, 1'b0);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
